// File: rtl/mem_loader_if.sv
// rtl/mem_loader_if.sv - byte stream in and byte write port out for the serial memory loader
interface mem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  mem_we;

    // master: the loader side; slave: the byte source and RAM side
    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - framed serial byte stream to RAM loader (SYNC, ADDR, LEN, DATA[LEN], CSUM)
module mem_loader #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'h55,
    parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_loader_if.master      bus,
    output logic              busy,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, WRITE, CSUM
    } state_t;

    state_t                state, state_nxt;
    logic [7:0]            addr_hi;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           len;
    logic [7:0]            sum;
    logic [31:0]           tcnt;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [7:0]            mem_wdata_q;

    logic                  accept;
    logic                  timeout;
    logic [7:0]            sum_nxt;
    logic [15:0]           len_hdr;

    assign accept  = bus.rx_valid && bus.rx_ready;
    assign timeout = (state != IDLE) && (state != WRITE) && (tcnt == TIMEOUT_CYCLES - 1);
    assign sum_nxt = sum + bus.rx_data;
    assign len_hdr = {len[15:8], bus.rx_data};

    // Strobe and handshake are decoded from state so reset removes them immediately
    assign bus.rx_ready  = (state != WRITE);
    assign bus.mem_we    = (state == WRITE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (accept && bus.rx_data == SYNC_BYTE) state_nxt = ADDR_H;
            ADDR_H: if (accept) state_nxt = ADDR_L;
            ADDR_L: if (accept) state_nxt = LEN_H;
            LEN_H:  if (accept) state_nxt = LEN_L;
            LEN_L:  if (accept) state_nxt = (len_hdr == 16'd0) ? CSUM : DATA;
            DATA:   if (accept) state_nxt = WRITE;
            WRITE:  state_nxt = (len == 16'd1) ? CSUM : DATA;
            CSUM:   if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A timeout wins over a byte arriving in the same cycle; that byte is lost
        if (timeout) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hi     <= 8'd0;
            addr        <= '0;
            len         <= 16'd0;
            sum         <= 8'd0;
            tcnt        <= 32'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            if (state == IDLE || accept) begin
                tcnt <= 32'd0;
            end else if (state != WRITE) begin
                tcnt <= tcnt + 1'b1;
            end

            if (timeout) begin
                frame_err <= 1'b1;
                err_code  <= 2'd2;
            end else begin
                case (state)
                    IDLE: if (accept && bus.rx_data == SYNC_BYTE) begin
                        sum      <= 8'd0;
                        err_code <= 2'd0;
                    end
                    ADDR_H: if (accept) begin
                        addr_hi <= bus.rx_data;
                        sum     <= sum_nxt;
                    end
                    ADDR_L: if (accept) begin
                        addr <= ADDR_WIDTH'({addr_hi, bus.rx_data});
                        sum  <= sum_nxt;
                    end
                    LEN_H: if (accept) begin
                        len[15:8] <= bus.rx_data;
                        sum       <= sum_nxt;
                    end
                    LEN_L: if (accept) begin
                        len <= len_hdr;
                        sum <= sum_nxt;
                    end
                    DATA: if (accept) begin
                        mem_addr_q  <= addr;
                        mem_wdata_q <= bus.rx_data;
                        sum         <= sum_nxt;
                    end
                    WRITE: begin
                        addr <= addr + 1'b1;
                        len  <= len - 1'b1;
                    end
                    CSUM: if (accept) begin
                        sum <= sum_nxt;
                        if (sum_nxt == 8'd0) begin
                            frame_ok <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - directed table-driven bench for mem_loader
module tb_mem_loader;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    mem_loader_if #(.ADDR_WIDTH(16)) bus ();

    mem_loader #(
        .ADDR_WIDTH    (16),
        .SYNC_BYTE     (8'h55),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0][7:0] frame;
        logic [7:0]       nb;
        logic [3:0][15:0] waddr;
        logic [3:0][7:0]  wdata;
        logic [7:0]       nw;
        logic             ok;
        logic [1:0]       code;
        logic [7:0]       busy_cyc;
    } vec_t;

    vec_t vecs[5];

    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int          ok_cnt    = 0;
    int          err_cnt   = 0;
    int          busy_cnt  = 0;
    int          both_cnt  = 0;
    int          ready_bad = 0;

    int tests = 0;
    int fails = 0;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wdata);
            if (bus.rx_ready) ready_bad++;
        end
        if (frame_ok) ok_cnt++;
        if (frame_err) err_cnt++;
        if (frame_ok && frame_err) both_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left on a falling edge; rx_valid stays high for back-to-back bytes
    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (w == 8) check("rx_accept_stall", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic run_vec(input int i);
        int base, ok0, err0, busy0;
        base  = wa_q.size();
        ok0   = ok_cnt;
        err0  = err_cnt;
        busy0 = busy_cnt;
        for (int j = 0; j < int'(vecs[i].nb); j++) send_byte(vecs[i].frame[11-j]);
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_nwrites", i), wa_q.size() - base, vecs[i].nw);
        for (int k = 0; k < int'(vecs[i].nw); k++) begin
            if (base + k < wa_q.size()) begin
                check($sformatf("v%0d_waddr%0d", i, k), wa_q[base+k], vecs[i].waddr[3-k]);
                check($sformatf("v%0d_wdata%0d", i, k), wd_q[base+k], vecs[i].wdata[3-k]);
            end
        end
        check($sformatf("v%0d_ok_pulses", i), ok_cnt - ok0, {31'd0, vecs[i].ok});
        check($sformatf("v%0d_err_pulses", i), err_cnt - err0, {31'd0, !vecs[i].ok});
        check($sformatf("v%0d_err_code", i), err_code, vecs[i].code);
        check($sformatf("v%0d_busy_cycles", i), busy_cnt - busy0, vecs[i].busy_cyc);
        check($sformatf("v%0d_busy_after", i), busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok0, err0, c;

        vecs[0] = '{frame: 96'h55_02_00_00_03_AA_BB_CC_CA_00_00_00, nb: 8'd9,
                    waddr: 64'h0200_0201_0202_0000, wdata: 32'hAA_BB_CC_00, nw: 8'd3,
                    ok: 1'b1, code: 2'd0, busy_cyc: 8'd11};
        vecs[1] = '{frame: 96'h55_02_00_00_03_AA_BB_CC_CB_00_00_00, nb: 8'd9,
                    waddr: 64'h0200_0201_0202_0000, wdata: 32'hAA_BB_CC_00, nw: 8'd3,
                    ok: 1'b0, code: 2'd1, busy_cyc: 8'd11};
        vecs[2] = '{frame: 96'h55_12_34_00_00_BA_00_00_00_00_00_00, nb: 8'd6,
                    waddr: 64'h0, wdata: 32'h0, nw: 8'd0,
                    ok: 1'b1, code: 2'd0, busy_cyc: 8'd5};
        vecs[3] = '{frame: 96'h55_FF_FF_00_02_11_22_CD_00_00_00_00, nb: 8'd8,
                    waddr: 64'hFFFF_0000_0000_0000, wdata: 32'h11_22_00_00, nw: 8'd2,
                    ok: 1'b1, code: 2'd0, busy_cyc: 8'd9};
        vecs[4] = '{frame: 96'h00_FF_55_02_00_00_03_AA_BB_CC_CA_00, nb: 8'd11,
                    waddr: 64'h0200_0201_0202_0000, wdata: 32'hAA_BB_CC_00, nw: 8'd3,
                    ok: 1'b1, code: 2'd0, busy_cyc: 8'd11};

        rst_n        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_rx_ready", bus.rx_ready, 1);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_code", err_code, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(i);

        // Single data byte: strobe one cycle after acceptance, ready low meanwhile
        ok0 = ok_cnt;
        send_byte(8'h55); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h77);
        check("lat_mem_we", bus.mem_we, 1);
        check("lat_rx_ready", bus.rx_ready, 0);
        check("lat_mem_addr", bus.mem_addr, 16'h0010);
        check("lat_mem_wdata", bus.mem_wdata, 8'h77);
        send_byte(8'h78);
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("lat_ok_pulse", ok_cnt - ok0, 1);

        // Timeout inside the header
        err0 = err_cnt;
        send_byte(8'h55);
        send_byte(8'h02);
        bus.rx_valid = 1'b0;
        c = 0;
        while (!frame_err && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("to_cycles", c, 100);
        check("to_err_code", err_code, 2);
        check("to_busy", busy, 0);
        repeat (2) @(negedge clk);
        check("to_err_pulses", err_cnt - err0, 1);
        check("to_err_code_held", err_code, 2);
        run_vec(0);

        // Reset while the first payload byte is being written
        send_byte(8'h55); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h03); send_byte(8'hAA);
        check("rw_mem_we_before", bus.mem_we, 1);
        ok0  = ok_cnt;
        err0 = err_cnt;
        #2 rst_n = 1'b0;
        bus.rx_valid = 1'b0;
        #1;
        check("rw_mem_we_async", bus.mem_we, 0);
        check("rw_busy_async", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rw_no_ok", ok_cnt - ok0, 0);
        check("rw_no_err", err_cnt - err0, 0);
        run_vec(4);

        check("never_both_pulses", both_cnt, 0);
        check("ready_low_on_write", ready_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
